// File: rtl/dmem_pkg.sv
// Shared encodings and constants for the data-memory responder.
// Imported by the lane aligner and the top level.
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Wide enough for the largest legal WAIT_CYCLES value (15).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } state_t;

  function automatic logic is_rejected(input logic [1:0] size, input logic [1:0] addr_lo);
    logic rej;
    rej = 1'b0;
    case (size)
      SZ_WORD: rej = (addr_lo != 2'b00);
      SZ_HALF: rej = addr_lo[0];
      SZ_BYTE: rej = 1'b0;
      default: rej = 1'b1;
    endcase
    return rej;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: write byte-enables and replicated write data,
// plus read extraction of the addressed lane(s) down to bit 0.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        reject
);

  assign reject = is_rejected(size, addr_lo);

  // Write data is replicated across lanes so each bank just takes its own slice.
  always_comb begin
    be    = 4'b0000;
    wdata = wdata_in;
    rdata = 32'h0;
    if (!reject) begin
      case (size)
        SZ_BYTE: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{wdata_in[7:0]}};
          case (addr_lo)
            2'd0:    rdata = {24'h0, rword[7:0]};
            2'd1:    rdata = {24'h0, rword[15:8]};
            2'd2:    rdata = {24'h0, rword[23:16]};
            default: rdata = {24'h0, rword[31:24]};
          endcase
        end
        SZ_HALF: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {2{wdata_in[15:0]}};
          rdata = addr_lo[1] ? {16'h0, rword[31:16]} : {16'h0, rword[15:0]};
        end
        SZ_WORD: begin
          be    = 4'b1111;
          wdata = wdata_in;
          rdata = rword;
        end
        default: begin
          be    = 4'b0000;
          rdata = 32'h0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory slave: IDLE/WAIT/ACK handshake in front of four
// byte-wide RAM banks, with alignment checking and registered bus outputs.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] DAD,
  input  logic [31:0] DDT_in,
  output logic [31:0] DDT_out,
  output logic        DDT_oe,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  output logic        ACKD_n,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [AW+1:0]   addr_q;
  logic            wr_q;
  logic [1:0]      size_q;
  logic [31:0]     data_q;

  logic [AW+1:0]   cur_addr;
  logic            cur_wr;
  logic [1:0]      cur_size;
  logic [31:0]     cur_data;
  logic [AW-1:0]   cur_idx;

  logic [31:0]     rword;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            reject;
  logic            we;

  logic            unused_dad;
  assign unused_dad = ^DAD[31:AW+2];

  // In IDLE the live bus feeds the aligner so a zero-wait access can ack on
  // its sample edge; afterwards only the captured copy matters.
  always_comb begin
    cur_addr = addr_q;
    cur_wr   = wr_q;
    cur_size = size_q;
    cur_data = data_q;
    if (state == ST_IDLE) begin
      cur_addr = DAD[AW+1:0];
      cur_wr   = WRITE;
      cur_size = SIZE;
      cur_data = DDT_in;
    end
  end

  assign cur_idx = cur_addr[AW+1:2];

  dmem_lane_align u_align (
    .addr_lo  (cur_addr[1:0]),
    .size     (cur_size),
    .wdata_in (cur_data),
    .rword    (rword),
    .be       (be),
    .wdata    (wdata),
    .rdata    (rdata),
    .reject   (reject)
  );

  assign we = (state == ST_ACK) && rst_n && wr_q;

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0] ram [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (we && be[b]) begin
        ram[cur_idx] <= wdata[8*b +: 8];
      end
    end

    assign rword[8*b +: 8] = ram[cur_idx];
  end

  // Bus outputs default to idle every cycle and are loaded only on the edge entering ACK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ACKD_n  <= 1'b1;
      err     <= 1'b0;
      DDT_oe  <= 1'b0;
      DDT_out <= 32'h0;
    end else begin
      ACKD_n  <= 1'b1;
      err     <= 1'b0;
      DDT_oe  <= 1'b0;
      DDT_out <= 32'h0;
      case (state)
        ST_IDLE: begin
          if (MREQ) begin
            addr_q <= DAD[AW+1:0];
            wr_q   <= WRITE;
            size_q <= SIZE;
            data_q <= DDT_in;
            cnt    <= CNT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state   <= ST_ACK;
              ACKD_n  <= 1'b0;
              err     <= reject;
              DDT_oe  <= !cur_wr;
              DDT_out <= cur_wr ? 32'h0 : rdata;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!MREQ) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state   <= ST_ACK;
              ACKD_n  <= 1'b0;
              err     <= reject;
              DDT_oe  <= !cur_wr;
              DDT_out <= cur_wr ? 32'h0 : rdata;
            end
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter WAIT_CYCLES, default 2, is the number of wait cycles inserted before ACKD_n asserts (0..15).
REQ-003 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit words in the array (a power of 2).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 DAD  input  32  byte address from the CPU.
REQ-007 DDT_in  input  32  write data, LSB-justified.
REQ-008 DDT_out  output  32  read data, LSB-justified and zero-extended.
REQ-009 DDT_oe  output  1  enables the tristate driver for DDT_out; it is resolved at the top level.
REQ-010 MREQ  input  1  access request, 1 = access.
REQ-011 WRITE  input  1  direction, 1 = write and 0 = read.
REQ-012 SIZE  input  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
REQ-013 ACKD_n  output  1  active-low acknowledge; asserted low for exactly one cycle per access.
REQ-014 err  output  1  one-cycle pulse, coincident with ACKD_n=0, that flags a rejected access.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and ACK.
REQ-016 IDLE: when MREQ=1 at a clock edge, the block SHALL capture DAD, WRITE, SIZE and DDT_in, load the counter with WAIT_CYCLES, and go to WAIT; if WAIT_CYCLES=0 it SHALL go directly to ACK.
REQ-017 WAIT: the counter SHALL decrement each cycle, and the FSM SHALL go to ACK on the edge where the counter is 1.
REQ-018 WAIT: if MREQ=0 at an edge, the access SHALL be abandoned: no write, no ack, next state IDLE.
REQ-019 ACK: ACKD_n=0 for one cycle, then the FSM SHALL go to IDLE unconditionally; a new request is sampled no earlier than the cycle after ACK.
REQ-020 Latency from the MREQ sample edge to ACKD_n low SHALL be WAIT_CYCLES+1 cycles.
REQ-021 Read in ACK: DDT_oe=1; DDT_out = selected lane(s) shifted to bit 0, with the upper bits zero.
REQ-022 Read outside ACK: DDT_oe=0 and DDT_out=0.
REQ-023 Write: the array SHALL update on the clock edge that ends the ACK cycle, byte-enabled.
REQ-024 Write lanes: byte writes DDT_in[7:0] to lane DAD[1:0]; half writes DDT_in[15:0] to lanes {DAD[1],0} and {DAD[1],1}; word writes all four lanes.
REQ-025 Byte order SHALL be little-endian: lane 0 = bits [7:0].
REQ-026 The word index SHALL be DAD[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-027 An access SHALL be rejected if it is misaligned (half with DAD[0]=1, or word with DAD[1:0]!=0) or uses SIZE=11.
REQ-028 A rejected access SHALL still be acknowledged, with err=1, no array write, and read data 0.
REQ-029 Changes on DAD, SIZE, WRITE or DDT_in after the capture edge SHALL have no effect on the access in flight.
REQ-030 The ACK decision SHALL depend only on the FSM state; it is independent of the CPU interlock.

Reset
REQ-031 While rst_n=0 at an edge: state is IDLE, counter is 0, ACKD_n=1, err=0, DDT_oe=0, DDT_out=0.
REQ-032 A reset during WAIT or ACK SHALL cancel the access; a write still pending in ACK is not performed.
REQ-033 Array contents SHALL NOT be reset.

Structure
REQ-034 Package dmem_pkg SHALL hold the SIZE encodings (SZ_WORD, SZ_HALF, SZ_BYTE), the state enum and the WAIT counter width constant.
REQ-035 Sub-module dmem_lane_align SHALL be combinational and generate the write byte-enables/shifted data and the read extraction, given the address low bits and SIZE.
REQ-036 The array SHALL be inferred as 4 byte-wide RAM banks; no other sub-modules are permitted.

Verification
REQ-037 WAIT_CYCLES=2: word write of 0xDEADBEEF to 0x10, then word read at 0x10 -> ACKD_n low 3 cycles after each MREQ sample; read returns 0xDEADBEEF with DDT_oe=1 only in ACK.
REQ-038 Starting from 0x11223344 at 0x20: byte write 0xAA to 0x23, half write 0x5566 to 0x20 -> word read returns 0xAA225566; byte read at 0x23 returns 0x000000AA.
REQ-039 Half write to 0x21 and SIZE=11 read -> ACK with err=1, word at 0x20 unchanged, read data 0.
REQ-040 MREQ dropped during WAIT for a write -> no ACK, memory unchanged, next request serviced normally.
REQ-041 rst_n=0 asserted in the ACK cycle of a write -> ACKD_n=1 on the next cycle and the write is not committed.
REQ-042 WAIT_CYCLES=0, DEPTH_WORDS=1024, write 0x1 to 0x1000 -> ack 1 cycle after the sample; a read of 0x0 returns 0x1 (wrap).
